// File: rtl/count_stream_monitor_pkg.sv
// Shared types and constants for the 4-bit wrap-counter stream monitor.
package count_pkg;

  localparam int NUM_W = 4;
  localparam logic [NUM_W-1:0] NUM_MAX = 4'd15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } state_t;

  function automatic logic [NUM_W-1:0] next_num(input logic [NUM_W-1:0] n);
    return n + NUM_W'(1);
  endfunction

endpackage

// File: rtl/count_stream_monitor_if.sv
// Sampled counter stream plus valid/ready statistics report.
// COUNT_STREAM_MONITOR_LAST_JUMP_EN adds the last-jump capture fields.
interface count_stream_monitor_if
  import count_pkg::*;
#(
  parameter int CNT_W = 8
);

  logic [NUM_W-1:0] number;
  logic             zero;
  logic             en;
  logic             rpt_ready;
  logic             rpt_valid;
  logic [CNT_W-1:0] rpt_wraps;
  logic [CNT_W-1:0] rpt_jumps;
  logic             rpt_zero_err;
  logic             rpt_overrun;
`ifdef COUNT_STREAM_MONITOR_LAST_JUMP_EN
  logic [NUM_W-1:0] rpt_jump_from;
  logic [NUM_W-1:0] rpt_jump_to;
`endif

  // Monitor side: consumes the stream, produces the report.
  modport master (
    input  number, zero, en, rpt_ready,
`ifdef COUNT_STREAM_MONITOR_LAST_JUMP_EN
    output rpt_jump_from, rpt_jump_to,
`endif
    output rpt_valid, rpt_wraps, rpt_jumps, rpt_zero_err, rpt_overrun
  );

  modport slave (
    output number, zero, en, rpt_ready,
`ifdef COUNT_STREAM_MONITOR_LAST_JUMP_EN
    input  rpt_jump_from, rpt_jump_to,
`endif
    input  rpt_valid, rpt_wraps, rpt_jumps, rpt_zero_err, rpt_overrun
  );

endinterface

// File: rtl/count_stream_monitor_sat_counter.sv
// Saturating event counter; count_inc is the value including this cycle's increment.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count_inc
);

  logic [CNT_W-1:0] count_p0;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic step);
    if (step && (v != {CNT_W{1'b1}})) return v + CNT_W'(1);
    return v;
  endfunction

  assign count_inc = sat_inc(count_p0, inc);

  always_ff @(posedge clk) begin
    if (rst || clr) count_p0 <= '0;
    else            count_p0 <= count_inc;
  end

endmodule

// File: rtl/count_stream_monitor.sv
// Checks the wrap counter's (number, zero) stream and reports per-window statistics.
// Define COUNT_STREAM_MONITOR_LAST_JUMP_EN to also report the last jump's endpoints.
module count_stream_monitor
  import count_pkg::*;
#(
  parameter int WINDOW = 64,
  parameter int CNT_W  = 8
) (
  input logic                    clk,
  input logic                    rst,
  count_stream_monitor_if.master mon
);

  localparam int WIN_W = $clog2(WINDOW);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);

  state_t           state_q, state_nxt;
  logic [NUM_W-1:0] prev_num_p0;
  logic [WIN_W-1:0] win_cnt_p0;
  logic             zerr_p0, ovr_p0;
  logic [NUM_W-1:0] expected_num;
  logic             do_run, win_end, wrap_ev, jump_ev, zerr_ev, rpt_load, rpt_drop;
  logic [CNT_W-1:0] wraps_snap, jumps_snap;

  logic             rpt_vld_p1;
  logic [CNT_W-1:0] rpt_wraps_p1, rpt_jumps_p1;
  logic             rpt_zerr_p1, rpt_ovr_p1;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    if (mon.en) begin
      case (state_q)
        IDLE:    state_nxt = PRIME;
        PRIME:   state_nxt = RUN;
        default: state_nxt = RUN;
      endcase
    end
  end

  // The enabled sample that leaves IDLE is the priming sample: it seeds prev_num
  // and opens window cycle 0 without a continuity check.
  always_comb begin
    expected_num = next_num(prev_num_p0);
    do_run       = mon.en && (state_q != IDLE);
    wrap_ev      = do_run && (mon.number == expected_num) && (prev_num_p0 == NUM_MAX);
    jump_ev      = do_run && (mon.number != expected_num);
    zerr_ev      = mon.en && (mon.zero != (mon.number == '0));
    win_end      = mon.en && (win_cnt_p0 == WIN_LAST);
    rpt_load     = win_end && (!rpt_vld_p1 || mon.rpt_ready);
    rpt_drop     = win_end && rpt_vld_p1 && !mon.rpt_ready;
  end

  sat_counter #(.CNT_W(CNT_W)) u_wraps (
    .clk(clk), .rst(rst), .inc(wrap_ev), .clr(win_end), .count_inc(wraps_snap)
  );

  sat_counter #(.CNT_W(CNT_W)) u_jumps (
    .clk(clk), .rst(rst), .inc(jump_ev), .clr(win_end), .count_inc(jumps_snap)
  );

  // Stage p0: window accumulation
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_num_p0 <= '0;
      win_cnt_p0  <= '0;
      zerr_p0     <= 1'b0;
      ovr_p0      <= 1'b0;
    end else begin
      if (mon.en) begin
        prev_num_p0 <= mon.number;
        win_cnt_p0  <= win_end ? '0 : win_cnt_p0 + WIN_W'(1);
        zerr_p0     <= win_end ? 1'b0 : (zerr_p0 | zerr_ev);
      end
      if (rpt_drop)      ovr_p0 <= 1'b1;
      else if (rpt_load) ovr_p0 <= 1'b0;
    end
  end

  // Stage p1: report register, held while valid and not accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      rpt_vld_p1   <= 1'b0;
      rpt_wraps_p1 <= '0;
      rpt_jumps_p1 <= '0;
      rpt_zerr_p1  <= 1'b0;
      rpt_ovr_p1   <= 1'b0;
    end else if (rpt_load) begin
      rpt_vld_p1   <= 1'b1;
      rpt_wraps_p1 <= wraps_snap;
      rpt_jumps_p1 <= jumps_snap;
      rpt_zerr_p1  <= zerr_p0 | zerr_ev;
      rpt_ovr_p1   <= ovr_p0;
    end else if (rpt_vld_p1 && mon.rpt_ready) begin
      rpt_vld_p1   <= 1'b0;
    end
  end

  assign mon.rpt_valid    = rpt_vld_p1;
  assign mon.rpt_wraps    = rpt_wraps_p1;
  assign mon.rpt_jumps    = rpt_jumps_p1;
  assign mon.rpt_zero_err = rpt_zerr_p1;
  assign mon.rpt_overrun  = rpt_ovr_p1;

`ifdef COUNT_STREAM_MONITOR_LAST_JUMP_EN
  logic [NUM_W-1:0] jfrom_p0, jto_p0, rpt_jfrom_p1, rpt_jto_p1;

  // Stage p0: last jump in the current window
  always_ff @(posedge clk) begin
    if (rst || win_end) begin
      jfrom_p0 <= '0;
      jto_p0   <= '0;
    end else if (jump_ev) begin
      jfrom_p0 <= prev_num_p0;
      jto_p0   <= mon.number;
    end
  end

  // Stage p1: jump endpoints follow the report load
  always_ff @(posedge clk) begin
    if (rst) begin
      rpt_jfrom_p1 <= '0;
      rpt_jto_p1   <= '0;
    end else if (rpt_load) begin
      rpt_jfrom_p1 <= jump_ev ? prev_num_p0 : jfrom_p0;
      rpt_jto_p1   <= jump_ev ? mon.number  : jto_p0;
    end
  end

  assign mon.rpt_jump_from = rpt_jfrom_p1;
  assign mon.rpt_jump_to   = rpt_jto_p1;
`endif

endmodule

// File: tb/tb_count_stream_monitor.sv
// Directed bench for count_stream_monitor (WINDOW=16/CNT_W=8 and WINDOW=64/CNT_W=2).
module tb_count_stream_monitor;

  logic clk = 1'b0;
  logic rst;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  count_stream_monitor_if #(.CNT_W(8)) a_if ();
  count_stream_monitor_if #(.CNT_W(2)) b_if ();

  count_stream_monitor #(.WINDOW(16), .CNT_W(8)) dut_a (.clk(clk), .rst(rst), .mon(a_if.master));
  count_stream_monitor #(.WINDOW(64), .CNT_W(2)) dut_b (.clk(clk), .rst(rst), .mon(b_if.master));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_rpt(input string tag, input logic v, input int w, input int j,
                         input logic z, input logic o, input int jf, input int jt);
    chk({tag, ".valid"},    32'(a_if.rpt_valid),    32'(v));
    chk({tag, ".wraps"},    32'(a_if.rpt_wraps),    32'(w));
    chk({tag, ".jumps"},    32'(a_if.rpt_jumps),    32'(j));
    chk({tag, ".zero_err"}, 32'(a_if.rpt_zero_err), 32'(z));
    chk({tag, ".overrun"},  32'(a_if.rpt_overrun),  32'(o));
`ifdef COUNT_STREAM_MONITOR_LAST_JUMP_EN
    chk({tag, ".jump_from"}, 32'(a_if.rpt_jump_from), 32'(jf));
    chk({tag, ".jump_to"},   32'(a_if.rpt_jump_to),   32'(jt));
`else
    if (jf < 0 || jt < 0) $display("note: negative jump field in %s", tag);
`endif
  endtask

  task automatic cyc(input logic [3:0] n, input logic z, input logic e, input logic r);
    a_if.number = n;
    a_if.zero = z;
    a_if.en = e;
    a_if.rpt_ready = r;
    @(posedge clk);
    #1;
  endtask

  // One 16-sample window: counting from start, optional jump at jk to jv,
  // optional corrupted zero flag at zk; ready per first/middle/last sample.
  task automatic run_win(input logic [3:0] start, input int jk, input logic [3:0] jv,
                         input int zk, input logic r0, input logic rmid, input logic rlast);
    logic [3:0] n;
    logic       r;
    n = start;
    for (int k = 0; k < 16; k++) begin
      if (k == jk) n = jv;
      r = (k == 0) ? r0 : ((k == 15) ? rlast : rmid);
      cyc(n, (n == 4'd0) ^ (k == zk), 1'b1, r);
      n = n + 4'd1;
    end
  endtask

  initial begin
    logic [3:0] bn;
    rst = 1'b1;
    a_if.number = '0; a_if.zero = 1'b1; a_if.en = 1'b0; a_if.rpt_ready = 1'b0;
    b_if.number = '0; b_if.zero = 1'b1; b_if.en = 1'b0; b_if.rpt_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_rpt("reset", 1'b0, 0, 0, 1'b0, 1'b0, 0, 0);
    chk("reset.b_valid", 32'(b_if.rpt_valid), 32'd0);
    rst = 1'b0;

    // Clean counting: first window primes on 0, second sees the 15->0 wrap.
    for (int i = 0; i < 32; i++) begin
      cyc(4'(i), (i % 16) == 0, 1'b1, 1'b1);
      if (i == 15) chk_rpt("w1", 1'b1, 0, 0, 1'b0, 1'b0, 0, 0);
      if (i == 16) chk("w1.accepted", 32'(a_if.rpt_valid), 32'd0);
      if (i == 31) chk_rpt("w2", 1'b1, 1, 0, 1'b0, 1'b0, 0, 0);
    end

    run_win(4'd0, 6, 4'd9, -1, 1'b1, 1'b1, 1'b1);
    chk_rpt("w3_jump", 1'b1, 2, 1, 1'b0, 1'b0, 5, 9);

    run_win(4'd3, -1, 4'd0, 13, 1'b1, 1'b1, 1'b1);
    chk_rpt("w4_zerr", 1'b1, 1, 0, 1'b1, 1'b0, 0, 0);

    run_win(4'd3, -1, 4'd0, -1, 1'b1, 1'b1, 1'b1);
    chk_rpt("w5_clean", 1'b1, 1, 0, 1'b0, 1'b0, 0, 0);

    // Consumer stalls across two window ends.
    run_win(4'd3, -1, 4'd0, -1, 1'b1, 1'b0, 1'b0);
    chk_rpt("w6_load", 1'b1, 1, 0, 1'b0, 1'b0, 0, 0);

    run_win(4'd3, 2, 4'd12, -1, 1'b0, 1'b0, 1'b0);
    chk_rpt("w7_held", 1'b1, 1, 0, 1'b0, 1'b0, 0, 0);

    run_win(4'd10, -1, 4'd0, -1, 1'b1, 1'b1, 1'b1);
    chk_rpt("w8_ovr", 1'b1, 1, 0, 1'b0, 1'b1, 0, 0);

    run_win(4'd10, -1, 4'd0, -1, 1'b1, 1'b0, 1'b1);
    chk_rpt("w9_ovr_clr", 1'b1, 1, 0, 1'b0, 1'b0, 0, 0);

    // Held report accepted on the same edge the next one loads; 9->0 is a jump, not a wrap.
    run_win(4'd0, -1, 4'd0, -1, 1'b0, 1'b0, 1'b1);
    chk_rpt("w10_b2b", 1'b1, 0, 1, 1'b0, 1'b0, 9, 0);

    // Reset while a report is pending.
    cyc(4'd0, 1'b1, 1'b1, 1'b0);
    chk("pre_rst.valid", 32'(a_if.rpt_valid), 32'd1);
    cyc(4'd1, 1'b0, 1'b1, 1'b0);
    rst = 1'b1;
    cyc(4'd2, 1'b0, 1'b1, 1'b0);
    rst = 1'b0;
    chk_rpt("rst_mid", 1'b0, 0, 0, 1'b0, 1'b0, 0, 0);

    run_win(4'd7, -1, 4'd0, -1, 1'b1, 1'b1, 1'b1);
    chk_rpt("post_rst", 1'b1, 1, 0, 1'b0, 1'b0, 0, 0);
    a_if.en = 1'b0;

    // Narrow counters: 5 wraps and 7 jumps in one 64-sample window saturate at 3.
    for (int k = 0; k < 64; k++) begin
      if (k < 10) bn = (k % 2 == 0) ? 4'd15 : 4'd0;
      else        bn = 4'(1 + ((k - 10) % 14));
      b_if.number = bn;
      b_if.zero = (bn == 4'd0);
      b_if.en = 1'b1;
      b_if.rpt_ready = 1'b1;
      @(posedge clk);
      #1;
    end
    chk("b.valid",    32'(b_if.rpt_valid),    32'd1);
    chk("b.wraps",    32'(b_if.rpt_wraps),    32'd3);
    chk("b.jumps",    32'(b_if.rpt_jumps),    32'd3);
    chk("b.zero_err", 32'(b_if.rpt_zero_err), 32'd0);
    chk("b.overrun",  32'(b_if.rpt_overrun),  32'd0);
    chk("a.idle_accepted", 32'(a_if.rpt_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
